// File: rtl/vx_result_gather.sv
// vx_result_gather: reassembles NUM_PACKETS lane-packets of one warp result
// into a full NUM_THREADS-wide result. It then presents that result to commit
// through a 1-deep output register.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_*                  lane-packet input (valid/ready, header, tmask/data,
//                         pid/sop/eop)
//   out_*                 assembled result (valid/ready, header, full tmask/data)
//   busy                  a partial instruction is held in the accumulator
//
// Optional: define RESULT_GATHER_CHECK_EN to add the protocol checker outputs
//   err      sticky protocol violation flag
//   cnt_drop saturating count of discarded partial instructions
module vx_result_gather #(
  parameter int unsigned NUM_THREADS = 8,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NW_WIDTH    = 2,
  parameter int unsigned NR_BITS     = 6,
  parameter int unsigned UUID_WIDTH  = 1,
  localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int unsigned PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [UUID_WIDTH-1:0]        in_uuid,
  input  logic [NW_WIDTH-1:0]          in_wid,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [NR_BITS-1:0]           in_rd,
  input  logic                         in_wb,
  input  logic [NUM_LANES-1:0]         in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]    in_data,
  input  logic [PID_WIDTH-1:0]         in_pid,
  input  logic                         in_sop,
  input  logic                         in_eop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [UUID_WIDTH-1:0]        out_uuid,
  output logic [NW_WIDTH-1:0]          out_wid,
  output logic [XLEN-1:0]              out_pc,
  output logic [NR_BITS-1:0]           out_rd,
  output logic                         out_wb,
  output logic [NUM_THREADS-1:0]       out_tmask,
  output logic [NUM_THREADS*XLEN-1:0]  out_data,
`ifdef RESULT_GATHER_CHECK_EN
  output logic                         err,
  output logic [15:0]                  cnt_drop,
`endif
  output logic                         busy
);

  localparam int unsigned PKT_W  = NUM_LANES * XLEN;
  localparam int unsigned DATA_W = NUM_THREADS * XLEN;

  // Accumulator state
  logic [NUM_THREADS-1:0] acc_tmask_q, acc_tmask_d;
  logic [DATA_W-1:0]      acc_data_q,  acc_data_d;
  logic [UUID_WIDTH-1:0]  acc_uuid_q,  acc_uuid_d;
  logic [NW_WIDTH-1:0]    acc_wid_q,   acc_wid_d;
  logic [XLEN-1:0]        acc_pc_q,    acc_pc_d;
  logic [NR_BITS-1:0]     acc_rd_q,    acc_rd_d;
  logic                   acc_wb_q,    acc_wb_d;
  logic                   busy_q,      busy_d;

  // Output register
  logic                   out_valid_q, out_valid_d;
  logic [UUID_WIDTH-1:0]  out_uuid_q,  out_uuid_d;
  logic [NW_WIDTH-1:0]    out_wid_q,   out_wid_d;
  logic [XLEN-1:0]        out_pc_q,    out_pc_d;
  logic [NR_BITS-1:0]     out_rd_q,    out_rd_d;
  logic                   out_wb_q,    out_wb_d;
  logic [NUM_THREADS-1:0] out_tmask_q, out_tmask_d;
  logic [DATA_W-1:0]      out_data_q,  out_data_d;

  // Effective packet framing and the merged accumulator + packet view
  logic                   eff_sop, eff_eop, fire;
  logic [PID_WIDTH-1:0]   pid_eff;
  logic [NUM_THREADS-1:0] mrg_tmask;
  logic [DATA_W-1:0]      mrg_data;

`ifdef RESULT_GATHER_CHECK_EN
  logic                   err_q, err_d;
  logic [15:0]            cnt_drop_q, cnt_drop_d;
  logic [PID_WIDTH-1:0]   prev_pid_q, prev_pid_d;
  logic                   viol;
`endif

  // Framing: single-packet configs treat every packet as sop&eop; a headless
  // packet while idle starts a new instruction.
  always_comb begin
    eff_sop = 1'b1;
    eff_eop = 1'b1;
    pid_eff = '0;
    if (NUM_PACKETS > 1) begin
      eff_sop = in_sop || !busy_q;
      eff_eop = in_eop;
      pid_eff = in_pid;
    end
  end

  // Only an eop needs the output register, so only it can stall
  assign in_ready = !eff_eop || !out_valid_q || out_ready;
  assign fire     = in_valid && in_ready;

  // Merge current packet into its slot; sop drops whatever was accumulated
  always_comb begin
    mrg_tmask = eff_sop ? '0 : acc_tmask_q;
    mrg_data  = eff_sop ? '0 : acc_data_q;
    for (int p = 0; p < int'(NUM_PACKETS); p++) begin
      if (pid_eff == PID_WIDTH'(p)) begin
        mrg_tmask[p*NUM_LANES +: NUM_LANES] = in_tmask;
        mrg_data[p*PKT_W +: PKT_W]          = in_data;
      end
    end
  end

  // Next-state for accumulator and output register
  always_comb begin
    acc_tmask_d = acc_tmask_q;
    acc_data_d  = acc_data_q;
    acc_uuid_d  = acc_uuid_q;
    acc_wid_d   = acc_wid_q;
    acc_pc_d    = acc_pc_q;
    acc_rd_d    = acc_rd_q;
    acc_wb_d    = acc_wb_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_uuid_d  = out_uuid_q;
    out_wid_d   = out_wid_q;
    out_pc_d    = out_pc_q;
    out_rd_d    = out_rd_q;
    out_wb_d    = out_wb_q;
    out_tmask_d = out_tmask_q;
    out_data_d  = out_data_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (fire) begin
      if (eff_eop) begin
        out_valid_d = 1'b1;
        out_tmask_d = mrg_tmask;
        out_data_d  = mrg_data;
        out_uuid_d  = eff_sop ? in_uuid : acc_uuid_q;
        out_wid_d   = eff_sop ? in_wid  : acc_wid_q;
        out_pc_d    = eff_sop ? in_pc   : acc_pc_q;
        out_rd_d    = eff_sop ? in_rd   : acc_rd_q;
        out_wb_d    = eff_sop ? in_wb   : acc_wb_q;
        acc_tmask_d = '0;
        acc_data_d  = '0;
        busy_d      = 1'b0;
      end else begin
        acc_tmask_d = mrg_tmask;
        acc_data_d  = mrg_data;
        busy_d      = 1'b1;
        if (eff_sop) begin
          acc_uuid_d = in_uuid;
          acc_wid_d  = in_wid;
          acc_pc_d   = in_pc;
          acc_rd_d   = in_rd;
          acc_wb_d   = in_wb;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_tmask_q <= '0;
      acc_data_q  <= '0;
      acc_uuid_q  <= '0;
      acc_wid_q   <= '0;
      acc_pc_q    <= '0;
      acc_rd_q    <= '0;
      acc_wb_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_uuid_q  <= '0;
      out_wid_q   <= '0;
      out_pc_q    <= '0;
      out_rd_q    <= '0;
      out_wb_q    <= 1'b0;
      out_tmask_q <= '0;
      out_data_q  <= '0;
    end else begin
      acc_tmask_q <= acc_tmask_d;
      acc_data_q  <= acc_data_d;
      acc_uuid_q  <= acc_uuid_d;
      acc_wid_q   <= acc_wid_d;
      acc_pc_q    <= acc_pc_d;
      acc_rd_q    <= acc_rd_d;
      acc_wb_q    <= acc_wb_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_uuid_q  <= out_uuid_d;
      out_wid_q   <= out_wid_d;
      out_pc_q    <= out_pc_d;
      out_rd_q    <= out_rd_d;
      out_wb_q    <= out_wb_d;
      out_tmask_q <= out_tmask_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_uuid  = out_uuid_q;
  assign out_wid   = out_wid_q;
  assign out_pc    = out_pc_q;
  assign out_rd    = out_rd_q;
  assign out_wb    = out_wb_q;
  assign out_tmask = out_tmask_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

`ifdef RESULT_GATHER_CHECK_EN
  // Protocol checker; raw sop is used so implicit-sop recovery still flags
  always_comb begin
    viol       = 1'b0;
    err_d      = err_q;
    cnt_drop_d = cnt_drop_q;
    prev_pid_d = prev_pid_q;
    if (fire && (NUM_PACKETS > 1)) begin
      viol = (in_sop && busy_q) ||
             (!in_sop && !busy_q) ||
             (busy_q && !in_sop && ((in_wid != acc_wid_q) || (in_uuid != acc_uuid_q))) ||
             (busy_q && !in_sop && (in_pid <= prev_pid_q));
      err_d      = err_q || viol;
      prev_pid_d = in_pid;
      if (in_sop && busy_q && (cnt_drop_q != 16'hFFFF)) begin
        cnt_drop_d = cnt_drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q      <= 1'b0;
      cnt_drop_q <= '0;
      prev_pid_q <= '0;
    end else begin
      err_q      <= err_d;
      cnt_drop_q <= cnt_drop_d;
      prev_pid_q <= prev_pid_d;
    end
  end

  assign err      = err_q;
  assign cnt_drop = cnt_drop_q;
`endif

endmodule

// File: tb/tb_vx_result_gather.sv
// Testbench for vx_result_gather: scenario tasks drive packets and push the
// expected assembled results into a scoreboard; a negedge monitor pops and
// compares each result as commit accepts it.
module tb_vx_result_gather;

  localparam int unsigned NT = 8;
  localparam int unsigned NL = 2;
  localparam int unsigned XL = 32;
  localparam int unsigned NW = 2;
  localparam int unsigned NR = 6;
  localparam int unsigned UW = 1;
  localparam int unsigned PW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [UW-1:0]     in_uuid = '0;
  logic [NW-1:0]     in_wid = '0;
  logic [XL-1:0]     in_pc = '0;
  logic [NR-1:0]     in_rd = '0;
  logic              in_wb = 1'b0;
  logic [NL-1:0]     in_tmask = '0;
  logic [NL*XL-1:0]  in_data = '0;
  logic [PW-1:0]     in_pid = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [UW-1:0]     out_uuid;
  logic [NW-1:0]     out_wid;
  logic [XL-1:0]     out_pc;
  logic [NR-1:0]     out_rd;
  logic              out_wb;
  logic [NT-1:0]     out_tmask;
  logic [NT*XL-1:0]  out_data;
  logic              busy;
`ifdef RESULT_GATHER_CHECK_EN
  logic              err;
  logic [15:0]       cnt_drop;
`endif

  vx_result_gather #(
    .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL),
    .NW_WIDTH(NW), .NR_BITS(NR), .UUID_WIDTH(UW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_pc(in_pc), .in_rd(in_rd), .in_wb(in_wb),
    .in_tmask(in_tmask), .in_data(in_data), .in_pid(in_pid),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uuid(out_uuid), .out_wid(out_wid), .out_pc(out_pc), .out_rd(out_rd),
    .out_wb(out_wb), .out_tmask(out_tmask), .out_data(out_data),
`ifdef RESULT_GATHER_CHECK_EN
    .err(err), .cnt_drop(cnt_drop),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [UW-1:0]    uuid;
    logic [NW-1:0]    wid;
    logic [XL-1:0]    pc;
    logic [NR-1:0]    rd;
    logic             wb;
    logic [NT-1:0]    tmask;
    logic [NT*XL-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic exp_t mk_exp(input logic [UW-1:0] uuid, input logic [NW-1:0] wid,
                                  input logic [XL-1:0] pc, input logic [NT-1:0] tmask,
                                  input logic [NT*XL-1:0] data);
    exp_t e;
    e.uuid = uuid; e.wid = wid; e.pc = pc; e.rd = NR'(pc); e.wb = 1'b1;
    e.tmask = tmask; e.data = data;
    return e;
  endfunction

  // Scoreboard monitor: every accepted output must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got pc=%h uuid=%h with no result expected", out_pc, out_uuid);
      end else begin
        mon_e = sb.pop_front();
        if (out_uuid !== mon_e.uuid || out_wid !== mon_e.wid || out_pc !== mon_e.pc ||
            out_rd !== mon_e.rd || out_wb !== mon_e.wb || out_tmask !== mon_e.tmask ||
            out_data !== mon_e.data) begin
          tests_failed++;
          $display("FAIL sb_result: got uuid=%h wid=%h pc=%h rd=%h wb=%b tmask=%h data=%h, expected uuid=%h wid=%h pc=%h rd=%h wb=%b tmask=%h data=%h",
                   out_uuid, out_wid, out_pc, out_rd, out_wb, out_tmask, out_data,
                   mon_e.uuid, mon_e.wid, mon_e.pc, mon_e.rd, mon_e.wb, mon_e.tmask, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_pkt(input logic [UW-1:0] uuid, input logic [NW-1:0] wid,
                           input logic [XL-1:0] pc, input logic [PW-1:0] pid,
                           input logic sop, input logic eop, input logic [NL-1:0] tm,
                           input logic [NL*XL-1:0] data);
    in_valid = 1'b1; in_uuid = uuid; in_wid = wid; in_pc = pc; in_rd = NR'(pc);
    in_wb = 1'b1; in_pid = pid; in_sop = sop; in_eop = eop; in_tmask = tm; in_data = data;
  endtask

  // Wait (bounded) for the driven packet to be accepted; returns #1 after the fire edge
  task automatic wait_accept(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        tests_run++; tests_failed++;
        $display("FAIL %s_accept_timeout: in_ready=%b after %0d cycles, expected 1", name, in_ready, n);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input string name, input logic [UW-1:0] uuid, input logic [NW-1:0] wid,
                          input logic [XL-1:0] pc, input logic [PW-1:0] pid,
                          input logic sop, input logic eop, input logic [NL-1:0] tm,
                          input logic [NL*XL-1:0] data);
    drive_pkt(uuid, wid, pc, pid, sop, eop, tm, data);
    wait_accept(name);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  function automatic logic [NL*XL-1:0] pkt_data(input logic [XL-1:0] base, input int p);
    return {XL'(base + XL'(2*p + 1)), XL'(base + XL'(2*p))};
  endfunction

  function automatic logic [NT*XL-1:0] full_data(input logic [XL-1:0] base);
    logic [NT*XL-1:0] d;
    for (int t = 0; t < int'(NT); t++) d[t*XL +: XL] = XL'(base + XL'(t));
    return d;
  endfunction

  task automatic test_reset();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_tmask !== '0 || out_data !== '0 ||
        out_pc !== '0 || out_uuid !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b busy=%b tmask=%h pc=%h ready=%b, expected 0 0 00 0 1",
               out_valid, busy, out_tmask, out_pc, in_ready);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      if (p == 3) sb.push_back(mk_exp(1'b1, 2'd2, 32'h1000, 8'hFF, full_data(32'h100)));
      send_pkt("full", 1'b1, 2'd2, 32'h1000, PW'(p), p == 0, p == 3, 2'b11, pkt_data(32'h100, p));
      if (p == 0) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL full_busy: got busy=%b, expected 1", busy);
        end
      end
    end
    idle();
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_latency: got valid=%b busy=%b, expected 1 0", out_valid, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_single_pulse: got valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_sparse();
    logic [NT*XL-1:0] d = '0;
    d[2*XL +: XL] = 32'hA;
    d[7*XL +: XL] = 32'hB;
    sb.push_back(mk_exp(1'b0, 2'd1, 32'h2000, 8'b1000_0100, d));
    send_pkt("sparse", 1'b0, 2'd1, 32'h2000, 2'd1, 1'b1, 1'b0, 2'b01, {32'h0, 32'hA});
    send_pkt("sparse", 1'b0, 2'd1, 32'h2000, 2'd3, 1'b0, 1'b1, 2'b10, {32'hB, 32'h0});
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [NT*XL-1:0] da = '0;
    da[4*XL +: XL] = 32'h30;
    da[5*XL +: XL] = 32'h31;
    out_ready = 1'b0;
    sb.push_back(mk_exp(1'b1, 2'd0, 32'h3000, 8'b0011_0000, da));
    send_pkt("stall_a", 1'b1, 2'd0, 32'h3000, 2'd2, 1'b1, 1'b1, 2'b11, {32'h31, 32'h30});
    for (int p = 0; p < 3; p++)
      send_pkt("stall_b", 1'b0, 2'd3, 32'h4000, PW'(p), p == 0, 1'b0, 2'b11, pkt_data(32'h400, p));
    sb.push_back(mk_exp(1'b0, 2'd3, 32'h4000, 8'hFF, full_data(32'h400)));
    drive_pkt(1'b0, 2'd3, 32'h4000, 2'd3, 1'b0, 1'b1, 2'b11, pkt_data(32'h400, 3));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h3000 || out_data !== da) begin
        tests_failed++;
        $display("FAIL stall_hold: got ready=%b valid=%b pc=%h data=%h, expected 0 1 3000 %h",
                 in_ready, out_valid, out_pc, out_data, da);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("stall_b_eop");
    idle();
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4000) begin
      tests_failed++;
      $display("FAIL stall_release: got valid=%b pc=%h, expected 1 4000", out_valid, out_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [NT*XL-1:0] d;
    logic [NT-1:0]    tm;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = '0; tm = '0;
      d[(i%4)*2*XL +: 2*XL] = pkt_data(32'h500, i);
      tm[(i%4)*2 +: 2] = 2'b11;
      sb.push_back(mk_exp(UW'(i%2), 2'd1, 32'h5000 + 32'(i), tm, d));
      send_pkt("b2b", UW'(i%2), 2'd1, 32'h5000 + 32'(i), PW'(i%4), 1'b1, 1'b1, 2'b11, pkt_data(32'h500, i));
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'h5000 + 32'(i)) begin
        tests_failed++;
        $display("FAIL b2b_no_bubble: cycle %0d got valid=%b pc=%h, expected 1 %h",
                 i, out_valid, out_pc, 32'h5000 + 32'(i));
      end
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_pkt("abort", 1'b1, 2'd1, 32'h6000, 2'd0, 1'b1, 1'b0, 2'b11, pkt_data(32'h600, 0));
    send_pkt("abort", 1'b1, 2'd1, 32'h6000, 2'd1, 1'b0, 1'b0, 2'b11, pkt_data(32'h600, 1));
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_state: got busy=%b valid=%b, expected 0 0", busy, out_valid);
    end
    for (int p = 0; p < 4; p++) begin
      if (p == 3) sb.push_back(mk_exp(1'b0, 2'd2, 32'h7000, 8'hFF, full_data(32'h700)));
      send_pkt("fresh", 1'b0, 2'd2, 32'h7000, PW'(p), p == 0, p == 3, 2'b11, pkt_data(32'h700, p));
    end
    idle();
    @(posedge clk); #1;
  endtask

`ifdef RESULT_GATHER_CHECK_EN
  task automatic test_check();
    tests_run++;
    if (err !== 1'b0 || cnt_drop !== 16'd0) begin
      tests_failed++;
      $display("FAIL check_clean: got err=%b cnt_drop=%0d, expected 0 0", err, cnt_drop);
    end
    send_pkt("chk_a", 1'b1, 2'd1, 32'h8000, 2'd0, 1'b1, 1'b0, 2'b11, pkt_data(32'h800, 0));
    send_pkt("chk_a", 1'b1, 2'd1, 32'h8000, 2'd1, 1'b0, 1'b0, 2'b11, pkt_data(32'h800, 1));
    send_pkt("chk_b", 1'b0, 2'd2, 32'h9000, 2'd0, 1'b1, 1'b0, 2'b11, pkt_data(32'h900, 0));
    tests_run++;
    if (err !== 1'b1 || cnt_drop !== 16'd1) begin
      tests_failed++;
      $display("FAIL check_drop: got err=%b cnt_drop=%0d, expected 1 1", err, cnt_drop);
    end
    for (int p = 1; p < 4; p++) begin
      if (p == 3) sb.push_back(mk_exp(1'b0, 2'd2, 32'h9000, 8'hFF, full_data(32'h900)));
      send_pkt("chk_b", 1'b0, 2'd2, 32'h9000, PW'(p), 1'b0, p == 3, 2'b11, pkt_data(32'h900, p));
    end
    idle();
    @(posedge clk); #1;
    tests_run++;
    if (err !== 1'b1 || cnt_drop !== 16'd1) begin
      tests_failed++;
      $display("FAIL check_sticky: got err=%b cnt_drop=%0d, expected 1 1", err, cnt_drop);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_full();
    test_sparse();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef RESULT_GATHER_CHECK_EN
    test_check();
`endif
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d results outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vx_result_gather.md
Name: vx_result_gather

Overview:
Commit-side counterpart of the packetizing dispatch path. An execute unit returns a warp's result as NUM_PACKETS lane-packets tagged with pid/sop/eop. This block reassembles them into one full-width (NUM_THREADS) result and presents it to the commit stage once per instruction. It sits between one execute-unit result port and the commit arbiter.

Parameters:
NUM_THREADS, 8, threads per warp; must be a multiple of NUM_LANES
NUM_LANES, 2, lanes per packet; NUM_PACKETS = NUM_THREADS/NUM_LANES, PID_WIDTH = max(1, clog2(NUM_PACKETS))
XLEN, 32, data width per lane
NW_WIDTH, 2, warp id width
NR_BITS, 6, destination register index width
UUID_WIDTH, 1, instruction uuid width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  result packet valid
in_ready  out  1  packet accepted when in_valid && in_ready
in_uuid  in  UUID_WIDTH  instruction uuid
in_wid  in  NW_WIDTH  warp id
in_pc  in  XLEN  instruction PC
in_rd  in  NR_BITS  destination register
in_wb  in  1  writeback enable
in_tmask  in  NUM_LANES  packet lane mask
in_data  in  NUM_LANES*XLEN  packet lane results, lane 0 in LSBs
in_pid  in  PID_WIDTH  packet index
in_sop  in  1  first packet of instruction
in_eop  in  1  last packet of instruction
out_valid  out  1  assembled result valid
out_ready  in  1  commit accepts
out_uuid/out_wid/out_pc/out_rd/out_wb  out  as inputs  header of assembled result
out_tmask  out  NUM_THREADS  full thread mask
out_data  out  NUM_THREADS*XLEN  full results, thread t at [t*XLEN +: XLEN]
busy  out  1  partial instruction held in accumulator

Behaviour:
- Reset: out_valid=0, busy=0, out_tmask=0, out_data=0, header outputs 0, accumulator cleared. Reset mid-instruction discards any partial result.
- Packet p maps to threads p*NUM_LANES .. p*NUM_LANES+NUM_LANES-1.
- Accumulator: acc_tmask[NUM_THREADS], acc_data, acc_header.
- On a non-eop fire, the packet's slot is written into the accumulator and busy=1.
- On an sop fire, the header is captured and all other slots of acc_tmask/acc_data are cleared in the same cycle.
- On an eop fire, the output register loads the accumulator merged with the current packet. The header comes from the current packet if sop, otherwise from acc_header. Then out_valid=1 on the next cycle (latency 1 from the eop fire), and the accumulator clears with busy=0.
- Slots never received have tmask 0 and data 0.
- A packet with sop && eop is a single-packet instruction and passes through with 1 cycle latency.
- in_ready = ~in_eop || ~out_valid || out_ready. Non-eop packets are always accepted; an eop stalls only while the output register is full and not draining.
- Output holds stable while out_valid && !out_ready. out_valid clears on out_ready unless a new eop fires in the same cycle, in which case back-to-back output continues with no bubble (full throughput).
- sop arriving while busy: the partial result is discarded and the new instruction starts.
- Non-sop packet arriving while !busy: treated as sop with implicit header capture.
- NUM_PACKETS==1: in_pid is ignored and every packet is treated as sop&eop, giving a pure 1-deep output register.
- No combinational path from out_ready to out_*; in_ready depends combinationally on out_ready only.

Optional Feature:
RESULT_GATHER_CHECK_EN: when defined, adds output port err (1 bit, sticky until reset) and cnt_drop (16 bits, saturating).
- err sets the cycle after any of these fires:
  - sop while busy;
  - non-sop while !busy;
  - in_wid or in_uuid differs from acc_header while busy and !sop;
  - in_pid not greater than the previous pid of the same instruction.
- cnt_drop increments once per discarded partial instruction.
- Functional datapath behaviour is identical with or without the macro. When undefined, the ports are absent and no checker logic is built.

Test Plan:
- Four packets pid 0..3, tmask 2'b11 each, data thread t = 0x100+t, sop on pid0, eop on pid3, out_ready=1 -> one out_valid pulse the cycle after the pid3 fire; out_tmask=8'hFF; out_data thread t = 0x100+t.
- Sparse: only pid1 (sop) and pid3 (eop) sent, tmask 2'b01 and 2'b10 -> out_tmask=8'b1000_0100; all other thread data = 0.
- out_ready=0 with an output pending; next instruction sends pid0..2 then pid3 eop -> pid0..2 accepted, in_ready=0 on pid3 until out_ready=1; second result appears the cycle after, first result unchanged while stalled.
- Back-to-back sop&eop packets every cycle with out_ready=1 -> out_valid stays 1 for N consecutive cycles with no bubbles and correct uuid order.
- Reset asserted after pid1 of a 4-packet instruction, then a fresh instruction -> no output for the aborted one; fresh result correct; busy=0 right after reset.
- With RESULT_GATHER_CHECK_EN: sop arrives while busy -> err=1 the following cycle, cnt_drop=1; the new instruction's result is still correct.
